// File: rtl/gpi_debounce_if.sv
// Pin-side bundle for gpi_debounce: raw pin levels in, debounced level and edge events out.
// The master modport is the debouncer; the slave modport is the pin driver and gp_i consumer.
interface gpi_debounce_if #(
  parameter int Width = 8
);
  logic [Width-1:0] raw_i;
  logic [Width-1:0] deb_o;
  logic [Width-1:0] rise_o;
  logic [Width-1:0] fall_o;

  modport master (
    input  raw_i,
    output deb_o,
    output rise_o,
    output fall_o
  );

  modport slave (
    output raw_i,
    input  deb_o,
    input  rise_o,
    input  fall_o
  );
endinterface

// File: rtl/gpi_debounce.sv
// Per-bit 2-flop synchroniser plus stability-counter debouncer; raw-to-deb_o latency StableCycles+2 edges, no backpressure.
// GPI_DEBOUNCE_EDGE_EN builds registered rise/fall event pulses; when undefined rise_o/fall_o are tied low.
module gpi_debounce #(
  parameter int               Width        = 8,
  parameter int               StableCycles = 50_000,
  parameter logic [Width-1:0] ResetValue   = '0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  gpi_debounce_if.master gpi
);

  localparam int             CntW   = (StableCycles > 1) ? $clog2(StableCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);

  logic [Width-1:0] s1_q, s2_q;
  logic [Width-1:0] deb_q, deb_d;
  logic [CntW-1:0]  cnt_q [Width];
  logic [CntW-1:0]  cnt_d [Width];

  // Sync flops reset to ResetValue so a held pin does not look like a change out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= ResetValue;
      s2_q <= ResetValue;
    end else begin
      s1_q <= gpi.raw_i;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < Width; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_q <= ResetValue;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign gpi.deb_o = deb_q;

`ifdef GPI_DEBOUNCE_EDGE_EN
  logic [Width-1:0] rise_q, fall_q;

  // Pulses load on the same edge as deb_q, so they line up with the visible level change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= deb_d & ~deb_q;
      fall_q <= ~deb_d & deb_q;
    end
  end

  assign gpi.rise_o = rise_q;
  assign gpi.fall_o = fall_q;
`else
  assign gpi.rise_o = '0;
  assign gpi.fall_o = '0;
`endif

endmodule
